tkm_uio_arbiter: RTL and testbench
==================================

# tkm_uio_arbiter

Sequencer and arbiter for the shared 8-bit bidirectional `uio` pad bus of `tkm_ic`. It grants the bus to one of `N_REQ` internal requesters at a time using round-robin priority. For a write owner it drives `uio_out`/`uio_oe`; for a read owner it captures `uio_in`. Between owners it inserts a mandatory turnaround gap with all `uio_oe` low, so two drivers never overlap on the pads. It sits between the project's functional units and the top-level `uio_*` ports.

## Interface
- `N_REQ`, 3: number of requesters, range 2..8.
- `MAX_BURST`, 8: beat limit per grant, range 1..255. Only used with `TKM_UIO_BURST_LIMIT_EN`.
- `TURNAROUND`, 1: gap cycles with `uio_oe`=0 after each grant, range 1..4.
- `clk` in 1: single clock, all flops rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design selected. Low blocks new grants and aborts the current one.
- `req` in N_REQ: per-requester bus request, level.
- `dir` in N_REQ: per-requester direction, 1=write (drive pads), 0=read. Sampled at grant.
- `last` in N_REQ: owner's final beat this cycle.
- `wdata` in 8*N_REQ: flattened write data, requester i at [8i+7:8i].
- `grant` out N_REQ: one-hot ownership, registered.
- `uio_in` in 8: pad input path.
- `uio_out` out 8: pad output path.
- `uio_oe` out 8: pad enable, 1=output.
- `rdata` out 8: captured read byte.
- `rvalid` out 1: `rdata` valid this cycle.
- `rid` out 3: requester index for `rdata`.

## Operation
- States: IDLE, OWN, GAP. Reset state is IDLE.
- IDLE:
  - If `ena`=1 and `req`≠0, pick the winner round-robin, starting at `ptr+1` mod N_REQ.
  - Latch `owner`, `owner_dir`=`dir[owner]`, and `ptr`=`owner`. Next state is OWN.
- OWN:
  - `grant[owner]`=1. Every OWN cycle is one beat.
  - Write owner: `uio_oe`=8'hFF and `uio_out`=`wdata[owner]`, a combinational mux through registered `owner`.
  - Read owner: `uio_oe`=8'h00. Next cycle `rdata`=`uio_in`, `rvalid`=1, `rid`=`owner`.
- OWN exits to GAP when any of these holds:
  - `last[owner]`=1. That beat is still performed.
  - `req[owner]`=0. The beat is not counted as data for a write, and no read capture happens.
  - `ena`=0.
  - The burst limit is reached, with the macro enabled.
- GAP: `grant`=0, `uio_oe`=0, `uio_out`=0. The block counts `TURNAROUND` cycles and then goes to IDLE.
- Simultaneous requests resolve strictly round-robin. `req` raised during OWN or GAP waits until IDLE.
- A requester that keeps `req` high is re-granted only after every other active requester has had a turn.
- `dir` changes while owning are ignored. `owner_dir` is fixed for the whole grant.
- `uio_oe` is decoded from registers only, so it cannot glitch on input changes.
- Reset mid-OWN: `uio_oe`, `grant` and `rvalid` drop asynchronously. `ptr` returns to N_REQ-1, so requester 0 wins first after reset.

## Timing
- Reset values:
  - `grant`=0, `uio_oe`=0, `uio_out`=0.
  - `rdata`=0, `rvalid`=0, `rid`=0.
  - state=IDLE, `ptr`=N_REQ-1, counters=0.
- `req` seen in IDLE at cycle t gives `grant` high at t+1, with `uio_oe`=8'hFF at t+1 for a write.
- Read data: `uio_in` sampled at the end of OWN cycle k appears on `rdata`/`rvalid` at k+1.
- `last` at cycle k:
  - `grant` and `uio_oe` are low at k+1.
  - GAP covers k+1..k+TURNAROUND.
  - IDLE is at k+TURNAROUND+1.
  - The earliest next grant is k+TURNAROUND+2.
- Minimum grant length is 1 cycle, when `last` is asserted on the first beat.

## Configuration
- `TKM_UIO_BURST_LIMIT_EN` defined:
  - An 8-bit beat counter is cleared at grant.
  - OWN is left after `MAX_BURST` beats even without `last`.
  - The requester must re-request to continue.
- Undefined: no counter. The owner holds the bus until `last`, `req` drop or `ena`=0.

## Structure
- Package `tkm_pkg` holds:
  - the state enum `tkm_uio_state_t` (IDLE, OWN, GAP);
  - `TKM_UIO_OE_DRIVE`=8'hFF and `TKM_UIO_OE_HIZ`=8'h00;
  - `TKM_RID_W`=3.
- Sub-module `tkm_rr_pick`: combinational round-robin picker.
  - Inputs: `req` and `ptr`.
  - Outputs: one-hot and index of the winner, plus `any`.
- The FSM, counters and data muxes live in `tkm_uio_arbiter`.

## Test plan
- Reset then single write: `req`=3'b001, `dir`=1, `wdata[0]`=8'hA5, `last` on the 3rd beat.
  - Expect `grant`=001 and `uio_oe`=FF with `uio_out`=A5 for 3 cycles.
  - Then `uio_oe`=00 for exactly 1 cycle before IDLE.
- Read capture: requester 1, `dir`=0, `uio_in`=8'h3C.
  - Expect `uio_oe`=00 throughout, and `rvalid`=1, `rdata`=3C, `rid`=1 one cycle after each beat.
- Round-robin: `req`=111 held, `last` on every beat.
  - Expect grant order 001→010→100→001, with a TURNAROUND gap between each.
- Abort:
  - `ena` dropped mid-write gives `uio_oe`=00 next cycle, and no new grant while `ena`=0.
  - `rst_n` pulsed mid-write drops `uio_oe`/`grant` immediately.
- Burst limit, with the macro on and `MAX_BURST`=4: owner holds `req` with no `last`.
  - Expect `grant` for exactly 4 cycles, then GAP.
  - With the macro off, the grant persists until `last`.

Source files
------------

// File: rtl/tkm_pkg.sv
// rtl/tkm_pkg.sv - shared types and constants for the tkm uio pad arbiter
package tkm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } tkm_uio_state_t;

  localparam logic [7:0] TKM_UIO_OE_DRIVE = 8'hFF;
  localparam logic [7:0] TKM_UIO_OE_HIZ   = 8'h00;
  localparam int         TKM_RID_W        = 3;

endpackage

// File: rtl/tkm_rr_pick.sv
// rtl/tkm_rr_pick.sv - combinational round-robin picker, search starts just after i_ptr
module tkm_rr_pick
  import tkm_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]     i_req,
  input  logic [TKM_RID_W-1:0] i_ptr,
  output logic [N_REQ-1:0]     o_onehot,
  output logic [TKM_RID_W-1:0] o_idx,
  output logic                 o_any
);

  int w_cand;

  // Candidates are visited in order ptr+1 .. ptr (mod N_REQ); the first active one wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand = (int'(i_ptr) + i) % N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (j == w_cand && !o_any && i_req[j]) begin
          o_any       = 1'b1;
          o_onehot[j] = 1'b1;
          o_idx       = TKM_RID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/tkm_uio_arbiter.sv
// rtl/tkm_uio_arbiter.sv - round-robin owner sequencer for the shared uio pad bus
// Optional per-grant beat cap compiled in with TKM_UIO_BURST_LIMIT_EN.
module tkm_uio_arbiter
  import tkm_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int MAX_BURST  = 8,
  parameter int TURNAROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     dir,
  input  logic [N_REQ-1:0]     last,
  input  logic [8*N_REQ-1:0]   wdata,
  output logic [N_REQ-1:0]     grant,
  input  logic [7:0]           uio_in,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe,
  output logic [7:0]           rdata,
  output logic                 rvalid,
  output logic [TKM_RID_W-1:0] rid
);

  tkm_uio_state_t         r_state;
  tkm_uio_state_t         w_state_nxt;
  logic [TKM_RID_W-1:0]   r_owner;
  logic                   r_owner_dir;
  logic [TKM_RID_W-1:0]   r_ptr;
  logic [2:0]             r_gap_cnt;
  logic [7:0]             r_rdata;
  logic                   r_rvalid;
  logic [TKM_RID_W-1:0]   r_rid;

  logic [N_REQ-1:0]       w_pick_onehot;
  logic [TKM_RID_W-1:0]   w_pick_idx;
  logic                   w_pick_any;
  logic                   w_take;
  logic [N_REQ-1:0]       w_owner_onehot;
  logic                   w_owner_req;
  logic                   w_owner_last;
  logic [7:0]             w_wsel;
  logic                   w_burst_hit;
  logic                   w_exit;
  logic                   w_capture;
  logic                   w_drive;

  tkm_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_take = (r_state == IDLE) && ena && w_pick_any;

  always_comb begin
    w_owner_onehot = '0;
    w_owner_req    = 1'b0;
    w_owner_last   = 1'b0;
    w_wsel         = 8'h00;
    for (int j = 0; j < N_REQ; j++) begin
      if (r_owner == TKM_RID_W'(j)) begin
        w_owner_onehot[j] = 1'b1;
        w_owner_req       = req[j];
        w_owner_last      = last[j];
        w_wsel            = wdata[8*j +: 8];
      end
    end
  end

`ifdef TKM_UIO_BURST_LIMIT_EN
  logic [7:0] r_beat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= 8'd0;
    end else if (w_take) begin
      r_beat_cnt <= 8'd0;
    end else if (r_state == OWN) begin
      r_beat_cnt <= r_beat_cnt + 8'd1;
    end
  end

  assign w_burst_hit = (r_state == OWN) && (r_beat_cnt == 8'(MAX_BURST - 1));
`else
  assign w_burst_hit = (MAX_BURST == 0);
`endif

  // A dropped request ends the grant on that same beat, so it is never treated as data.
  assign w_exit    = w_owner_last || !w_owner_req || !ena || w_burst_hit;
  assign w_capture = (r_state == OWN) && !r_owner_dir && w_owner_req && ena;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_take) w_state_nxt = OWN;
      OWN:  if (w_exit) w_state_nxt = GAP;
      GAP:  if (r_gap_cnt == 3'(TURNAROUND - 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_owner_dir <= 1'b0;
      r_ptr       <= TKM_RID_W'(N_REQ - 1);
      r_gap_cnt   <= 3'd0;
      r_rdata     <= 8'h00;
      r_rvalid    <= 1'b0;
      r_rid       <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= w_capture;
      if (w_take) begin
        r_owner     <= w_pick_idx;
        r_owner_dir <= |(dir & w_pick_onehot);
        r_ptr       <= w_pick_idx;
      end
      if (r_state == GAP) begin
        r_gap_cnt <= r_gap_cnt + 3'd1;
      end else begin
        r_gap_cnt <= 3'd0;
      end
      if (w_capture) begin
        r_rdata <= uio_in;
        r_rid   <= r_owner;
      end
    end
  end

  // Pad enable depends only on flops, so input activity can never glitch it.
  assign w_drive = (r_state == OWN) && r_owner_dir;
  assign grant   = (r_state == OWN) ? w_owner_onehot : '0;
  assign uio_oe  = w_drive ? TKM_UIO_OE_DRIVE : TKM_UIO_OE_HIZ;
  assign uio_out = w_drive ? w_wsel : 8'h00;
  assign rdata   = r_rdata;
  assign rvalid  = r_rvalid;
  assign rid     = r_rid;

endmodule

// File: tb/tb_tkm_uio_arbiter.sv
// tb/tb_tkm_uio_arbiter.sv - vector table and scoreboard bench for tkm_uio_arbiter
module tb_tkm_uio_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [2:0]  req;
  logic [2:0]  dir;
  logic [2:0]  last;
  logic [23:0] wdata;
  logic [2:0]  grant;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [2:0]  rid;

  tkm_uio_arbiter #(
    .N_REQ      (3),
    .MAX_BURST  (4),
    .TURNAROUND (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .dir     (dir),
    .last    (last),
    .wdata   (wdata),
    .grant   (grant),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .rid     (rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic [2:0] req;
    logic [2:0] dir;
    logic [2:0] last;
    logic [7:0] uin;
    logic [2:0] e_grant;
    logic [7:0] e_oe;
    logic [7:0] e_out;
    logic       e_rv;
    logic [7:0] e_rdata;
    logic [2:0] e_rid;
  } vec_t;

  vec_t vt[$];
  vec_t exp_q[$];
  int   n_pass;
  int   n_tot;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic e, input logic [2:0] rq, input logic [2:0] d,
                     input logic [2:0] l, input logic [7:0] ui, input logic [2:0] g,
                     input logic [7:0] oe, input logic [7:0] o, input logic rv,
                     input logic [7:0] rd, input logic [2:0] ri);
    vec_t v;
    v.ena = e; v.req = rq; v.dir = d; v.last = l; v.uin = ui;
    v.e_grant = g; v.e_oe = oe; v.e_out = o; v.e_rv = rv; v.e_rdata = rd; v.e_rid = ri;
    vt.push_back(v);
  endtask

  initial begin
    vec_t e;
    logic burst_on;
    n_pass = 0;
    n_tot  = 0;
`ifdef TKM_UIO_BURST_LIMIT_EN
    burst_on = 1'b1;
`else
    burst_on = 1'b0;
`endif
    rst_n  = 1'b1;
    ena    = 1'b0;
    req    = 3'b000;
    dir    = 3'b000;
    last   = 3'b000;
    uio_in = 8'h00;
    wdata  = {8'h77, 8'h5A, 8'hA5};

    // single write by requester 0, last on third beat, dir change ignored
    add(1, 3'b001, 3'b001, 3'b000, 8'h00, 3'b001, 8'hFF, 8'hA5, 0, 8'h00, 3'd0);
    add(1, 3'b001, 3'b000, 3'b000, 8'h00, 3'b001, 8'hFF, 8'hA5, 0, 8'h00, 3'd0);
    add(1, 3'b001, 3'b000, 3'b000, 8'h00, 3'b001, 8'hFF, 8'hA5, 0, 8'h00, 3'd0);
    add(1, 3'b001, 3'b000, 3'b001, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b001, 3'b001, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b001, 3'b001, 3'b000, 8'h00, 3'b001, 8'hFF, 8'hA5, 0, 8'h00, 3'd0);
    add(1, 3'b001, 3'b001, 3'b001, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b000, 3'b000, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    // read by requester 1, then a grant ended by req drop (no capture)
    add(1, 3'b010, 3'b000, 3'b000, 8'h00, 3'b010, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b010, 3'b000, 3'b000, 8'h3C, 3'b010, 8'h00, 8'h00, 1, 8'h3C, 3'd1);
    add(1, 3'b010, 3'b000, 3'b010, 8'hC3, 3'b000, 8'h00, 8'h00, 1, 8'hC3, 3'd1);
    add(1, 3'b000, 3'b000, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b010, 3'b000, 3'b000, 8'h11, 3'b010, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b000, 3'b000, 3'b000, 8'h22, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b000, 3'b000, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    // round robin, all requesting, last on every beat; pointer sits at 1
    add(1, 3'b111, 3'b111, 3'b111, 8'h00, 3'b100, 8'hFF, 8'h77, 0, 8'h00, 3'd0);
    add(1, 3'b111, 3'b111, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b111, 3'b111, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b111, 3'b111, 3'b111, 8'h00, 3'b001, 8'hFF, 8'hA5, 0, 8'h00, 3'd0);
    add(1, 3'b111, 3'b111, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b111, 3'b111, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b111, 3'b111, 3'b111, 8'h00, 3'b010, 8'hFF, 8'h5A, 0, 8'h00, 3'd0);
    add(1, 3'b111, 3'b111, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b111, 3'b111, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b111, 3'b111, 3'b111, 8'h00, 3'b100, 8'hFF, 8'h77, 0, 8'h00, 3'd0);
    add(1, 3'b111, 3'b111, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b111, 3'b111, 3'b111, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b000, 3'b000, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    // ena dropped mid-write, no grant while ena low
    add(1, 3'b001, 3'b001, 3'b000, 8'h00, 3'b001, 8'hFF, 8'hA5, 0, 8'h00, 3'd0);
    add(0, 3'b001, 3'b001, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(0, 3'b001, 3'b001, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(0, 3'b001, 3'b001, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(0, 3'b001, 3'b001, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b001, 3'b001, 3'b000, 8'h00, 3'b001, 8'hFF, 8'hA5, 0, 8'h00, 3'd0);
    add(1, 3'b001, 3'b001, 3'b001, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b000, 3'b000, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    // requester 1 holds req without last: 4-beat cap only with the limit compiled in
    add(1, 3'b010, 3'b010, 3'b000, 8'h00, 3'b010, 8'hFF, 8'h5A, 0, 8'h00, 3'd0);
    add(1, 3'b010, 3'b010, 3'b000, 8'h00, 3'b010, 8'hFF, 8'h5A, 0, 8'h00, 3'd0);
    add(1, 3'b010, 3'b010, 3'b000, 8'h00, 3'b010, 8'hFF, 8'h5A, 0, 8'h00, 3'd0);
    add(1, 3'b010, 3'b010, 3'b000, 8'h00, 3'b010, 8'hFF, 8'h5A, 0, 8'h00, 3'd0);
    if (burst_on) begin
      add(1, 3'b010, 3'b010, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
      add(1, 3'b010, 3'b010, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    end else begin
      add(1, 3'b010, 3'b010, 3'b000, 8'h00, 3'b010, 8'hFF, 8'h5A, 0, 8'h00, 3'd0);
      add(1, 3'b010, 3'b010, 3'b000, 8'h00, 3'b010, 8'hFF, 8'h5A, 0, 8'h00, 3'd0);
    end
    add(1, 3'b010, 3'b010, 3'b000, 8'h00, 3'b010, 8'hFF, 8'h5A, 0, 8'h00, 3'd0);
    add(1, 3'b010, 3'b010, 3'b010, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);
    add(1, 3'b000, 3'b000, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00, 0, 8'h00, 3'd0);

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset grant",   32'(grant),   32'h0);
    chk("reset uio_oe",  32'(uio_oe),  32'h0);
    chk("reset uio_out", 32'(uio_out), 32'h0);
    chk("reset rdata",   32'(rdata),   32'h0);
    chk("reset rvalid",  32'(rvalid),  32'h0);
    chk("reset rid",     32'(rid),     32'h0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      ena    = vt[i].ena;
      req    = vt[i].req;
      dir    = vt[i].dir;
      last   = vt[i].last;
      uio_in = vt[i].uin;
      exp_q.push_back(vt[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d grant", i),   32'(grant),   32'(e.e_grant));
      chk($sformatf("v%0d uio_oe", i),  32'(uio_oe),  32'(e.e_oe));
      chk($sformatf("v%0d uio_out", i), 32'(uio_out), 32'(e.e_out));
      chk($sformatf("v%0d rvalid", i),  32'(rvalid),  32'(e.e_rv));
      if (e.e_rv) begin
        chk($sformatf("v%0d rdata", i), 32'(rdata), 32'(e.e_rdata));
        chk($sformatf("v%0d rid", i),   32'(rid),   32'(e.e_rid));
      end
    end

    // asynchronous reset in the middle of a write, then requester 0 must win first
    ena  = 1'b1;
    req  = 3'b001;
    dir  = 3'b001;
    last = 3'b000;
    @(posedge clk);
    #1;
    chk("pre-reset grant",  32'(grant),  32'h1);
    chk("pre-reset uio_oe", 32'(uio_oe), 32'hFF);
    rst_n = 1'b0;
    #1;
    chk("async reset grant",   32'(grant),   32'h0);
    chk("async reset uio_oe",  32'(uio_oe),  32'h0);
    chk("async reset uio_out", 32'(uio_out), 32'h0);
    #2 rst_n = 1'b1;
    req = 3'b111;
    dir = 3'b111;
    @(posedge clk);
    #1;
    chk("post-reset grant",   32'(grant),   32'h1);
    chk("post-reset uio_out", 32'(uio_out), 32'hA5);
    req = 3'b000;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
